// File: rtl/fnd_pkg.sv
// Shared constants and types for the multiplexed six-digit seven-segment scan driver.
package fnd_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [5:0] AN_OFF  = 6'h3F;

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } slot_state_e;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder; non-decimal codes blank the digit.
module bcd_to_seg7
  import fnd_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Map each BCD digit to its segment pattern.
  always_comb begin
    seg_o = SEG_OFF;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/fnd_scan_driver.sv
// Six-digit multiplexed FND scanner with per-frame snapshot and per-slot blanking gap.
// Define FND_LZB_EN to enable leading-zero blanking on digits 5, 4 and 3.
module fnd_scan_driver
  import fnd_pkg::*;
#(
  parameter logic [18:0] SCAN_DIV     = 19'd49_999,
  parameter logic [18:0] BLANK_CYCLES = 19'd500,
  parameter logic [5:0]  DP_MASK      = 6'b010100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] bcd0,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd2,
  input  logic [3:0] bcd3,
  input  logic [3:0] bcd4,
  input  logic [3:0] bcd5,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an
);

  logic [18:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  snap_q [NUM_DIGITS];
  logic [3:0]  bcd_s  [NUM_DIGITS];
  logic        slot_end_s, capture_s;
  slot_state_e state_s;
  logic [3:0]  digit_s;
  logic [5:0]  an_sel_s;
  logic        dp_sel_s;
  logic        lzb_blank_s;
  logic [6:0]  seg_dec_s;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic [5:0]  an_q, an_d;

  assign bcd_s[0] = bcd0;
  assign bcd_s[1] = bcd1;
  assign bcd_s[2] = bcd2;
  assign bcd_s[3] = bcd3;
  assign bcd_s[4] = bcd4;
  assign bcd_s[5] = bcd5;

  // Prescaler, slot sequencing and blank/drive phase of the current slot.
  always_comb begin
    slot_end_s = (cnt_q == SCAN_DIV);
    capture_s  = slot_end_s && (idx_q == 3'd5);
    cnt_d      = cnt_q + 19'd1;
    idx_d      = idx_q;
    if (slot_end_s) begin
      cnt_d = 19'd0;
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end else begin
      cnt_d = cnt_q + 19'd1;
    end
    state_s = (cnt_q < BLANK_CYCLES) ? ST_BLANK : ST_DRIVE;
  end

  // Select the snapshot digit, enable pattern and decimal-point bit for the active slot.
  always_comb begin
    digit_s  = 4'd0;
    an_sel_s = AN_OFF;
    dp_sel_s = 1'b0;
    case (idx_q)
      3'd0: begin digit_s = snap_q[0]; an_sel_s = 6'b111110; dp_sel_s = DP_MASK[0]; end
      3'd1: begin digit_s = snap_q[1]; an_sel_s = 6'b111101; dp_sel_s = DP_MASK[1]; end
      3'd2: begin digit_s = snap_q[2]; an_sel_s = 6'b111011; dp_sel_s = DP_MASK[2]; end
      3'd3: begin digit_s = snap_q[3]; an_sel_s = 6'b110111; dp_sel_s = DP_MASK[3]; end
      3'd4: begin digit_s = snap_q[4]; an_sel_s = 6'b101111; dp_sel_s = DP_MASK[4]; end
      3'd5: begin digit_s = snap_q[5]; an_sel_s = 6'b011111; dp_sel_s = DP_MASK[5]; end
      default: begin digit_s = 4'd0; an_sel_s = AN_OFF; dp_sel_s = 1'b0; end
    endcase
  end

`ifdef FND_LZB_EN
  logic zero5_s, zero4_s, zero3_s;

  // A high digit is blanked only while it and every digit above it are zero.
  always_comb begin
    zero5_s     = (snap_q[5] == 4'd0);
    zero4_s     = zero5_s && (snap_q[4] == 4'd0);
    zero3_s     = zero4_s && (snap_q[3] == 4'd0);
    lzb_blank_s = 1'b0;
    case (idx_q)
      3'd3:    lzb_blank_s = zero3_s;
      3'd4:    lzb_blank_s = zero4_s;
      3'd5:    lzb_blank_s = zero5_s;
      default: lzb_blank_s = 1'b0;
    endcase
  end
`else
  assign lzb_blank_s = 1'b0;
`endif

  bcd_to_seg7 u_dec (
    .bcd_i (digit_s),
    .seg_o (seg_dec_s)
  );

  // Next pin values; the enable stays scanned even when the digit itself is blanked.
  always_comb begin
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    an_d  = AN_OFF;
    case (state_s)
      ST_DRIVE: begin
        an_d = an_sel_s;
        if (lzb_blank_s) begin
          seg_d = SEG_OFF;
          dp_d  = 1'b1;
        end else begin
          seg_d = seg_dec_s;
          dp_d  = ~dp_sel_s;
        end
      end
      default: begin
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        an_d  = AN_OFF;
      end
    endcase
  end

  // Counter, slot index and output pin registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 19'd0;
      idx_q <= 3'd0;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
      an_q  <= AN_OFF;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
    end
  end

  // Frame snapshot, taken on the last clock of slot 5 so one frame shows one coherent value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) snap_q[i] <= 4'd0;
    end else if (capture_s) begin
      for (int i = 0; i < NUM_DIGITS; i++) snap_q[i] <= bcd_s[i];
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Directed, table-driven bench for fnd_scan_driver with SCAN_DIV=3, BLANK_CYCLES=1 (24-clock frames).
module tb_fnd_scan_driver;

  logic       clk;
  logic       reset;
  logic [3:0] bcd0, bcd1, bcd2, bcd3, bcd4, bcd5;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  typedef struct packed {
    logic [23:0] bcd;   // {bcd5..bcd0}
    logic [41:0] seg;   // expected seg per slot, {slot5..slot0}
    logic [5:0]  dp;    // expected active-low dp per slot
  } vec_t;

  vec_t       vecs [5];
  logic [5:0] an_tab [6];

  fnd_scan_driver #(
    .SCAN_DIV     (19'd3),
    .BLANK_CYCLES (19'd1),
    .DP_MASK      (6'b010100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bcd0  (bcd0),
    .bcd1  (bcd1),
    .bcd2  (bcd2),
    .bcd3  (bcd3),
    .bcd4  (bcd4),
    .bcd5  (bcd5),
    .seg   (seg),
    .dp    (dp),
    .an    (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int slot, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s slot %0d: got %0h, expected %0h", nm, slot, act, exp);
    end
  endtask

  task automatic chk_pins(input string nm, input int slot, input logic [5:0] e_an,
                          input logic [6:0] e_seg, input logic e_dp);
    chk({nm, ".an"}, slot, 32'(an), 32'(e_an));
    chk({nm, ".seg"}, slot, 32'(seg), 32'(e_seg));
    chk({nm, ".dp"}, slot, 32'(dp), 32'(e_dp));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    edge_n++;
  endtask

  task automatic set_bcd(input logic [23:0] w);
    bcd0 = w[3:0];
    bcd1 = w[7:4];
    bcd2 = w[11:8];
    bcd3 = w[15:12];
    bcd4 = w[19:16];
    bcd5 = w[23:20];
  endtask

  // Walk one full frame: each slot is one blank clock then three driven clocks.
  task automatic check_frame(input string nm, input logic [41:0] e_seg, input logic [5:0] e_dp);
    for (int s = 0; s < 6; s++) begin
      for (int p = 0; p < 4; p++) begin
        tick();
        if (p == 0) chk_pins({nm, ".blank"}, s, 6'h3F, 7'h7F, 1'b1);
        else        chk_pins(nm, s, an_tab[s], e_seg[7*s +: 7], e_dp[s]);
      end
    end
  endtask

  initial begin
    an_tab[0] = 6'h3E; an_tab[1] = 6'h3D; an_tab[2] = 6'h3B;
    an_tab[3] = 6'h37; an_tab[4] = 6'h2F; an_tab[5] = 6'h1F;

    vecs[0] = '{bcd: 24'h654321, seg: {7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79}, dp: 6'b101011};
    vecs[1] = '{bcd: 24'h6543B1, seg: {7'h02, 7'h12, 7'h19, 7'h30, 7'h7F, 7'h79}, dp: 6'b101011};
`ifdef FND_LZB_EN
    vecs[2] = '{bcd: 24'h000507, seg: {7'h7F, 7'h7F, 7'h7F, 7'h12, 7'h40, 7'h78}, dp: 6'b111011};
`else
    vecs[2] = '{bcd: 24'h000507, seg: {7'h40, 7'h40, 7'h40, 7'h12, 7'h40, 7'h78}, dp: 6'b101011};
`endif
    vecs[3] = '{bcd: 24'h890876, seg: {7'h00, 7'h10, 7'h40, 7'h00, 7'h78, 7'h02}, dp: 6'b101011};
    vecs[4] = '{bcd: 24'hF0C5A0, seg: {7'h7F, 7'h40, 7'h7F, 7'h12, 7'h7F, 7'h40}, dp: 6'b101011};

    reset = 1'b1;
    set_bcd(24'h654321);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_pins("reset_held", 0, 6'h3F, 7'h7F, 1'b1);

    // Release: snapshot still zero during the first frame.
    reset  = 1'b1;
    edge_n = 0;
    tick();
    chk_pins("start.blank", 0, 6'h3F, 7'h7F, 1'b1);
    tick();
    chk_pins("start.zero", 0, 6'h3E, 7'h40, 1'b1);

    for (int v = 0; v < 5; v++) begin
      set_bcd(vecs[v].bcd);
      do tick(); while (edge_n % 24 != 0);
      check_frame($sformatf("vec%0d", v), vecs[v].seg, vecs[v].dp);
    end

    // Inputs changed mid-frame must wait for the next snapshot.
    set_bcd(24'h654321);
    do tick(); while (edge_n % 24 != 0);
    repeat (10) tick();
    chk_pins("midchg.slot2", 2, 6'h3B, 7'h30, 1'b0);
    set_bcd(24'h658329);
    repeat (4) tick();
    chk_pins("midchg.slot3_old", 3, 6'h37, 7'h19, 1'b1);
    do tick(); while (edge_n % 24 != 0);
    repeat (2) tick();
    chk_pins("midchg.slot0_new", 0, 6'h3E, 7'h10, 1'b1);
    repeat (12) tick();
    chk_pins("midchg.slot3_new", 3, 6'h37, 7'h00, 1'b1);

    // Asynchronous reset in the middle of a driven slot-3 clock.
    #2 reset = 1'b0;
    #1 chk_pins("async_reset", 3, 6'h3F, 7'h7F, 1'b1);
    repeat (2) @(negedge clk);
    chk_pins("async_reset_hold", 3, 6'h3F, 7'h7F, 1'b1);
    reset  = 1'b1;
    edge_n = 0;
`ifdef FND_LZB_EN
    check_frame("post_reset", {7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40}, 6'b111011);
`else
    check_frame("post_reset", {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 6'b101011);
`endif
    repeat (2) tick();
    chk_pins("post_reset.capture", 0, 6'h3E, 7'h10, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
